// File: rtl/multisum_feeder.sv
// multisum_feeder: initiator for the MultiSum four-operand adder.
//
// Takes a stream of words terminated by in_last and packs them into groups of four.
// Each group is presented on ms_in0..ms_in3 with a one-cycle ms_start pulse. The block then
// waits for a rising edge of ms_done and adds ms_sum into an accumulator. After the last group
// of a vector, the total is offered on a valid/ready output.
//
// Parameters
//   WIDTH    data width of stream words, operands and sums
//   TIMEOUT  cycles allowed in WAIT before abort (only with MULTISUM_FEEDER_TIMEOUT_EN)
//
// Ports
//   clk, reset               clock; synchronous active-low reset
//   in_data/valid/last/ready input word stream
//   ms_in0..3, ms_start      operands and start pulse to MultiSum
//   ms_sum, ms_done          MultiSum result and done level (rising edge used)
//   out_sum/valid/ready      accumulated vector total
//   err                      one-cycle timeout abort pulse (constant 0 without the macro)
//
// Build option
//   MULTISUM_FEEDER_TIMEOUT_EN  adds the WAIT timeout and the DRAIN state.

module multisum_feeder #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] ms_in0,
    output logic [WIDTH-1:0] ms_in1,
    output logic [WIDTH-1:0] ms_in2,
    output logic [WIDTH-1:0] ms_in3,
    output logic             ms_start,
    input  logic [WIDTH-1:0] ms_sum,
    input  logic             ms_done,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err
);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("TIMEOUT must be nonzero");
    end

`ifdef MULTISUM_FEEDER_TIMEOUT_EN
    typedef enum logic [2:0] {StFill, StIssue, StWait, StEmit, StDrain} state_e;

    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
`else
    typedef enum logic [1:0] {StFill, StIssue, StWait, StEmit} state_e;
`endif

    state_e                  state_q, state_d;
    logic [1:0]              slot_cnt_q, slot_cnt_d;
    logic [3:0][WIDTH-1:0]   slot_q, slot_d;
    logic                    last_q, last_d;
    logic [WIDTH-1:0]        acc_q, acc_d;
    logic                    done_prev_q, done_prev_d;
    logic                    in_ready_q, in_ready_d;

    logic accept;
    logic done_edge;

    assign accept    = in_valid & in_ready_q;
    assign done_edge = ms_done & ~done_prev_q;

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        slot_d      = slot_q;
        last_d      = last_q;
        acc_d       = acc_q;
        done_prev_d = done_prev_q;
        err         = 1'b0;
`ifdef MULTISUM_FEEDER_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    // Starting a fresh group clears all slots so a short group is zero-padded.
                    if (slot_cnt_q == 2'd0) begin
                        slot_d = '0;
                    end
                    slot_d[slot_cnt_q] = in_data;
                    slot_cnt_d         = slot_cnt_q + 2'd1;
                    if (in_last || (slot_cnt_q == 2'd3)) begin
                        state_d    = StIssue;
                        last_d     = in_last;
                        slot_cnt_d = 2'd0;
                    end
                end
            end

            StIssue: begin
                // A done level already high here must not count as an edge in WAIT.
                done_prev_d = ms_done;
                state_d     = StWait;
`ifdef MULTISUM_FEEDER_TIMEOUT_EN
                tmo_cnt_d   = '0;
`endif
            end

            StWait: begin
                done_prev_d = ms_done;
                if (done_edge) begin
                    acc_d   = acc_q + ms_sum;
                    state_d = last_q ? StEmit : StFill;
                end
`ifdef MULTISUM_FEEDER_TIMEOUT_EN
                else if (tmo_cnt_q == TmoLast) begin
                    err     = 1'b1;
                    acc_d   = '0;
                    state_d = last_q ? StFill : StDrain;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
`endif
            end

            StEmit: begin
                if (out_ready) begin
                    acc_d   = '0;
                    state_d = StFill;
                end
            end

`ifdef MULTISUM_FEEDER_TIMEOUT_EN
            StDrain: begin
                // Discard the rest of the aborted vector.
                if (accept && in_last) begin
                    state_d = StFill;
                end
            end
`endif

            default: state_d = StFill;
        endcase
    end

`ifdef MULTISUM_FEEDER_TIMEOUT_EN
    assign in_ready_d = (state_d == StFill) || (state_d == StDrain);
`else
    assign in_ready_d = (state_d == StFill);
`endif

    // in_ready is registered so it reads 0 while reset is applied.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StFill;
            slot_cnt_q  <= '0;
            slot_q      <= '0;
            last_q      <= 1'b0;
            acc_q       <= '0;
            done_prev_q <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef MULTISUM_FEEDER_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            slot_q      <= slot_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            done_prev_q <= done_prev_d;
            in_ready_q  <= in_ready_d;
`ifdef MULTISUM_FEEDER_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign ms_in0    = slot_q[0];
    assign ms_in1    = slot_q[1];
    assign ms_in2    = slot_q[2];
    assign ms_in3    = slot_q[3];
    assign ms_start  = (state_q == StIssue);
    assign out_valid = (state_q == StEmit);
    assign out_sum   = out_valid ? acc_q : '0;

endmodule
